regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file for the pipelined RISC core, generalising the 8×16 two-read/one-write file. It has configurable width and depth, NRD read ports, and two prioritised write ports (ALU and load writeback). It adds same-cycle write-to-read bypass and a per-register busy scoreboard that decode uses to stall on outstanding producers. It sits between decode (reads, allocation) and writeback (writes).

## Interface
- XLEN, 16: data width in bits.
- NREGS, 8: number of architectural registers; power of two, ≥2. AW = $clog2(NREGS) is derived and is not a port parameter.
- NRD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = same-cycle write data is forwarded to reads; 0 = reads return stored value only.
- ZERO_REG, 1: 1 = r0 reads 0, ignores writes, is never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_addr  in  NRD*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data; port i at [i*XLEN +: XLEN].
- rd_busy  out  NRD  1 = read port i's register has an outstanding producer.
- we0 / wa0 / wd0  in  1 / AW / XLEN  write port 0 (ALU writeback).
- we1 / wa1 / wd1  in  1 / AW / XLEN  write port 1 (load writeback); has priority over port 0.
- alloc_en  in  1  request to mark alloc_addr busy (instruction issued with destination).
- alloc_addr  in  AW  destination being allocated.
- alloc_ok  out  1  combinational; 1 = allocation accepted this cycle.
- busy_vec  out  NREGS  registered scoreboard state.

## Operation
- Storage: NREGS×XLEN flops plus NREGS busy flops.
- Effective write: a port is effective when its we is 1, and its address is not 0 when ZERO_REG=1.
- Write collision: if both ports are effective and wa0==wa1, wd1 is stored and wd0 is dropped.
- Read value, per port:
  - ZERO_REG=1 and rd_addr=0: returns 0.
  - Otherwise, with BYPASS=1: an effective port-1 write to the same address supplies wd1; else an effective port-0 write supplies wd0; else the stored value.
  - With BYPASS=0: always the stored value.
- rd_busy[i]:
  - Equals busy_vec[rd_addr_i].
  - With BYPASS=1 it is forced to 0 when an effective write to that address occurs this cycle.
  - It is always 0 for r0 when ZERO_REG=1.
- alloc_ok = alloc_en & (ZERO_REG=0 or alloc_addr≠0) & ~busy_vec[alloc_addr].
  - An allocation to a register being written this cycle is accepted (the old producer retires).
  - A rejected allocation changes no state; decode must stall and retry.
- Busy update at each rising edge, per register r:
  - Set if alloc_ok and alloc_addr=r.
  - Else cleared if an effective write to r occurs.
  - Else held.
  - Set wins over clear in the same cycle.
- Write to a non-busy register: data is stored and busy stays 0; this is legal and not flagged.
- Out-of-range addresses cannot occur because NREGS is a power of two.

## Timing
- Reads, rd_busy and alloc_ok are combinational; there is no read latency.
- Writes and busy updates take effect at the rising edge.
  - A value written in cycle N is visible from storage in cycle N+1.
  - With BYPASS=1 it is also visible in cycle N.
- Reset is asynchronous, active-low, and takes effect immediately:
  - all registers = 0;
  - busy_vec = 0;
  - rd_data = 0 unless bypassed;
  - rd_busy = 0.
- Reset asserted mid-operation discards same-edge writes and allocations.
- The first edge after deassertion is a normal cycle.
- No internal state beyond storage and scoreboard; there is no multi-cycle FSM.

## Test plan
- **Reset:** assert rst_n=0 mid-stream after writing r3=0x1234 → every read returns 0x0000, busy_vec=0; after release, reading r3 returns 0x0000.
- **Write collision:** we0=we1=1, wa0=wa1=5, wd0=0xAAAA, wd1=0x5555 → next cycle r5 reads 0x5555.
- **Same-cycle bypass:**
  - BYPASS=1: write r2=0xBEEF while reading r2 → same cycle rd_data=0xBEEF and rd_busy=0.
  - BYPASS=0: same stimulus returns the old value, and 0xBEEF appears the next cycle.
- **Zero register:** write r0=0xFFFF on both ports and allocate r0 → r0 reads 0, alloc_ok=0, busy_vec[0]=0.
- **Scoreboard:**
  - Allocate r4 → busy_vec[4]=1 next cycle.
  - Re-allocating r4 gives alloc_ok=0.
  - A port-0 write to r4 with a simultaneous alloc of r4 gives alloc_ok=1, and busy_vec[4] stays 1 while r4 holds the written data.
  - A subsequent port-0 write to r4 with no allocation clears busy_vec[4] to 0.
- **Parameter sweep:** repeat the scenarios at XLEN=32, NREGS=16, NRD=3 with random traffic against a reference model → zero mismatches over 10k cycles.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Parametrised multi-port register file with NRD combinational
//             read ports, two prioritised write ports (port 1 = load
//             writeback wins over port 0 = ALU writeback), optional
//             same-cycle write-to-read bypass, optional hard-wired zero
//             register, and a per-register busy scoreboard used by decode
//             to stall on outstanding producers.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
   parameter int  XLEN     = 16,
   parameter int  NREGS    = 8,
   parameter int  NRD      = 2,
   parameter int  BYPASS   = 1,
   parameter int  ZERO_REG = 1,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // read ports, packed: port i at [i*AW +: AW] / [i*XLEN +: XLEN]
   input  logic [NRD*AW-1:0]     rd_addr_i,
   output logic [NRD*XLEN-1:0]   rd_data_o,
   output logic [NRD-1:0]        rd_busy_o,
   // write port 0 (ALU writeback)
   input  logic                  we0_i,
   input  logic [AW-1:0]         wa0_i,
   input  logic [XLEN-1:0]       wd0_i,
   // write port 1 (load writeback), higher priority
   input  logic                  we1_i,
   input  logic [AW-1:0]         wa1_i,
   input  logic [XLEN-1:0]       wd1_i,
   // destination allocation from decode
   input  logic                  alloc_en_i,
   input  logic [AW-1:0]         alloc_addr_i,
   output logic                  alloc_ok_o,
   output logic [NREGS-1:0]      busy_vec_o
);

   // ------------------------------------------------------------------------
   // Storage and scoreboard state
   // ------------------------------------------------------------------------
   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // A write to r0 is not effective when r0 is hard-wired to zero, so r0
   // never changes and never clears (or sets) its busy bit.
   logic             eff0;
   logic             eff1;
   logic [NREGS-1:0] hit0_vec;   // one-hot: register targeted by port 0
   logic [NREGS-1:0] hit1_vec;   // one-hot: register targeted by port 1
   logic [NREGS-1:0] wr_hit;     // registers written at the coming edge

   assign eff0 = we0_i && ((ZERO_REG == 0) || (wa0_i != '0));
   assign eff1 = we1_i && ((ZERO_REG == 0) || (wa1_i != '0));

   // Decode the effective write addresses into per-register hit vectors
   always_comb begin
      hit0_vec = '0;
      hit1_vec = '0;
      if (eff0) hit0_vec[wa0_i] = 1'b1;
      if (eff1) hit1_vec[wa1_i] = 1'b1;
   end

   assign wr_hit = hit0_vec | hit1_vec;

   // ------------------------------------------------------------------------
   // Allocation: accepted when the target is free, or when its current
   // producer retires by writing it this very cycle.
   // ------------------------------------------------------------------------
   assign alloc_ok_o = alloc_en_i
                    && ((ZERO_REG == 0) || (alloc_addr_i != '0))
                    && (!busy_q[alloc_addr_i] || wr_hit[alloc_addr_i]);

   // Scoreboard next state: retire on write, then allocation overrides
   always_comb begin
      busy_d = busy_q & ~wr_hit;
      if (alloc_ok_o) busy_d[alloc_addr_i] = 1'b1;
   end

   // Scoreboard register with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec_o = busy_q;

   // ------------------------------------------------------------------------
   // Register storage: one enabled flop word per architectural register.
   // On an address collision port 1 supplies the data and port 0 is dropped.
   // ------------------------------------------------------------------------
   for (genvar r = 0; r < NREGS; r++) begin : g_reg
      logic [XLEN-1:0] wdata;

      assign wdata = hit1_vec[r] ? wd1_i : wd0_i;

      // Capture the winning write data for this register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            regs_q[r] <= '0;
         end else if (wr_hit[r]) begin
            regs_q[r] <= wdata;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read ports: zero register first, then (optionally) the bypass network
   // with port 1 ahead of port 0, then the stored value.
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic            zero_rd;
      logic            byp0;
      logic            byp1;
      logic [XLEN-1:0] rdata;

      assign ra      = rd_addr_i[i*AW +: AW];
      assign zero_rd = (ZERO_REG != 0) && (ra == '0);
      assign byp0    = (BYPASS != 0) && hit0_vec[ra];
      assign byp1    = (BYPASS != 0) && hit1_vec[ra];

      // Select the read value for this port
      always_comb begin
         if (zero_rd) begin
            rdata = '0;
         end else if (byp1) begin
            rdata = wd1_i;
         end else if (byp0) begin
            rdata = wd0_i;
         end else begin
            rdata = regs_q[ra];
         end
      end

      assign rd_data_o[i*XLEN +: XLEN] = rdata;

      // A forwarded value is final, so the register is not reported busy
      assign rd_busy_o[i] = !zero_rd && busy_q[ra] && !(byp0 || byp1);
   end

endmodule
`default_nettype wire
